// File: rtl/svi_cas_pkg.sv
// Shared types and constants for the SVI cassette playback stage.
package svi_cas_pkg;

  // Playback FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEADER,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_BITS,
    ST_PAUSED,
    ST_END
  } state_t;

  // Externally visible status codes
  localparam logic [2:0] STATUS_IDLE   = 3'd0;
  localparam logic [2:0] STATUS_LEADER = 3'd1;
  localparam logic [2:0] STATUS_DATA   = 3'd2;
  localparam logic [2:0] STATUS_PAUSED = 3'd3;
  localparam logic [2:0] STATUS_END    = 3'd4;

  // Default tone timing for a 42.66 MHz clk_sys
  localparam int DEF_HALF_1     = 8888;
  localparam int DEF_HALF_0     = 17775;
  localparam int DEF_LEADER_CYC = 4800;

  // FETCH/LOAD/START/BITS are all reported as DATA
  function automatic logic [2:0] status_of(input state_t s);
    case (s)
      ST_IDLE:   return STATUS_IDLE;
      ST_LEADER: return STATUS_LEADER;
      ST_PAUSED: return STATUS_PAUSED;
      ST_END:    return STATUS_END;
      default:   return STATUS_DATA;
    endcase
  endfunction

endpackage

// File: rtl/svi_cas_player_if.sv
// Read port between the playback stage (master) and the CAS byte buffer (slave).
interface svi_cas_player_if #(parameter int ADDR_W = 18);
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_rd_o;
  logic [7:0]        mem_data_i;

  modport master (output mem_addr_o, output mem_rd_o, input mem_data_i);
  modport slave  (input mem_addr_o, input mem_rd_o, output mem_data_i);
endinterface

// File: rtl/svi_cas_player_fsk_gen.sv
// FSK square-wave generator: one bit (or one leader cycle) per start strobe.
// A bit always begins high and toggles at each half-period boundary. When the
// last half-period expires without a new start, the generator holds there
// (wave low, bit_done high) so a pause that lands on a bit end loses nothing.
module svi_fsk_gen
  import svi_cas_pkg::*;
#(
  parameter int HALF_1 = DEF_HALF_1,
  parameter int HALF_0 = DEF_HALF_0
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  input  logic start_i,
  input  logic bit_i,
  input  logic leader_i,
  output logic wave_o,
  output logic bit_done_o
);

  localparam int HMAX = (HALF_0 > HALF_1) ? HALF_0 : HALF_1;
  localparam int CW   = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam logic [CW-1:0] RELOAD_0 = CW'(HALF_0 - 1);
  localparam logic [CW-1:0] RELOAD_1 = CW'(HALF_1 - 1);

  logic          wave_q, wave_d;
  logic          long_q, long_d;
  logic          active_q, active_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    halves_q, halves_d;
  logic          last;
  logic          start_long;

  assign last       = (cnt_q == '0) && (halves_q == 2'd0);
  assign start_long = !leader_i && !bit_i;

  // Half-period countdown and half counter; start wins over pause
  always_comb begin
    wave_d   = wave_q;
    long_d   = long_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    halves_d = halves_q;
    if (clr_i) begin
      wave_d   = 1'b0;
      long_d   = 1'b0;
      active_d = 1'b0;
      cnt_d    = '0;
      halves_d = 2'd0;
    end else if (start_i) begin
      active_d = 1'b1;
      wave_d   = 1'b1;
      long_d   = start_long;
      cnt_d    = start_long ? RELOAD_0 : RELOAD_1;
      // 0 bit and leader cycle: 2 halves; 1 bit: 4 halves
      halves_d = (leader_i || !bit_i) ? 2'd1 : 2'd3;
    end else if (en_i && active_q && !last) begin
      if (cnt_q == '0) begin
        wave_d   = ~wave_q;
        halves_d = halves_q - 2'd1;
        cnt_d    = long_q ? RELOAD_0 : RELOAD_1;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // Generator state registers
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wave_q   <= 1'b0;
      long_q   <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
      halves_q <= 2'd0;
    end else begin
      wave_q   <= wave_d;
      long_q   <= long_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      halves_q <= halves_d;
    end
  end

  assign wave_o     = wave_q;
  assign bit_done_o = active_q && last;

endmodule

// File: rtl/svi_cas_player.sv
// SVI cassette playback: fetches CAS bytes and plays them as FSK audio.
// Build option CAS_RELEADER_EN: resuming from pause replays a full leader and
// restarts the interrupted byte; otherwise playback resumes at the frozen point.
module svi_cas_player
  import svi_cas_pkg::*;
#(
  parameter int ADDR_W     = 18,
  parameter int HALF_1     = DEF_HALF_1,
  parameter int HALF_0     = DEF_HALF_0,
  parameter int LEADER_CYC = DEF_LEADER_CYC
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              play_i,
  input  logic              rewind_i,
  input  logic [ADDR_W-1:0] size_i,
  svi_cas_player_if.master  mem,
  output logic              data_o,
  output logic [2:0]        status_o
);

  localparam int LW = (LEADER_CYC > 1) ? $clog2(LEADER_CYC) : 1;

  state_t            state_q, state_d;
  state_t            resume_q, resume_d;
  logic [ADDR_W-1:0] pos_q, pos_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [LW-1:0]     lead_cnt_q, lead_cnt_d;
  logic              lead_run_q, lead_run_d;
  logic [2:0]        status_q, status_d;

  logic fsk_start, fsk_bit, fsk_leader, fsk_en, bit_done, wave;
  logic have_byte;

  assign have_byte = pos_q < size_i;
  // The tone generator freezes only while the FSM sits in PAUSED
  assign fsk_en    = (state_q != ST_PAUSED);

  svi_fsk_gen #(
    .HALF_1 (HALF_1),
    .HALF_0 (HALF_0)
  ) u_fsk (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .clr_i      (rewind_i),
    .en_i       (fsk_en),
    .start_i    (fsk_start),
    .bit_i      (fsk_bit),
    .leader_i   (fsk_leader),
    .wave_o     (wave),
    .bit_done_o (bit_done)
  );

  // Next-state logic. The FETCH decision (read or END) is taken on the way
  // into FETCH so the read strobe is already registered in the FETCH cycle and
  // the data arrives in LOAD, keeping the inter-byte gap at two clocks.
  always_comb begin
    state_d    = state_q;
    resume_d   = resume_q;
    pos_d      = pos_q;
    addr_d     = addr_q;
    rd_d       = 1'b0;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    lead_cnt_d = lead_cnt_q;
    lead_run_d = lead_run_q;
    fsk_start  = 1'b0;
    fsk_bit    = 1'b0;
    fsk_leader = 1'b0;
    if (rewind_i) begin
      state_d    = ST_IDLE;
      pos_d      = '0;
      addr_d     = '0;
      lead_run_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (play_i && (size_i != '0)) begin
            state_d    = ST_LEADER;
            lead_run_d = 1'b0;
          end
        end
        ST_LEADER: begin
          if (!play_i) begin
            state_d  = ST_PAUSED;
            resume_d = ST_LEADER;
          end else if (!lead_run_q) begin
            fsk_start  = 1'b1;
            fsk_leader = 1'b1;
            lead_run_d = 1'b1;
            lead_cnt_d = LW'(LEADER_CYC - 1);
          end else if (bit_done) begin
            if (lead_cnt_q == '0) begin
              lead_run_d = 1'b0;
              if (have_byte) begin
                state_d = ST_FETCH;
                rd_d    = 1'b1;
                addr_d  = pos_q;
              end else begin
                state_d = ST_END;
              end
            end else begin
              lead_cnt_d = lead_cnt_q - LW'(1);
              fsk_start  = 1'b1;
              fsk_leader = 1'b1;
            end
          end
        end
        ST_FETCH: begin
          state_d = ST_LOAD;
        end
        ST_LOAD: begin
          shift_d   = mem.mem_data_i;
          pos_d     = pos_q + ADDR_W'(1);
          state_d   = ST_START;
          fsk_start = 1'b1;
          fsk_bit   = 1'b1;
        end
        ST_START: begin
          if (!play_i) begin
            state_d  = ST_PAUSED;
            resume_d = ST_START;
          end else if (bit_done) begin
            fsk_start = 1'b1;
            fsk_bit   = shift_q[7];
            bit_idx_d = 3'd7;
            state_d   = ST_BITS;
          end
        end
        ST_BITS: begin
          if (!play_i) begin
            state_d  = ST_PAUSED;
            resume_d = ST_BITS;
          end else if (bit_done) begin
            if (bit_idx_q == 3'd0) begin
              if (have_byte) begin
                state_d = ST_FETCH;
                rd_d    = 1'b1;
                addr_d  = pos_q;
              end else begin
                state_d = ST_END;
              end
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              fsk_start = 1'b1;
              fsk_bit   = shift_q[6];
              bit_idx_d = bit_idx_q - 3'd1;
            end
          end
        end
        ST_PAUSED: begin
          if (play_i) begin
`ifdef CAS_RELEADER_EN
            state_d    = ST_LEADER;
            lead_run_d = 1'b0;
            // Position already points past the interrupted byte; step back to refetch it
            if (resume_q != ST_LEADER) begin
              pos_d = pos_q - ADDR_W'(1);
            end
`else
            state_d = resume_q;
`endif
          end
        end
        ST_END: begin
          state_d = ST_END;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    status_d = status_of(state_d);
  end

  // FSM, position, shift register and registered outputs
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      resume_q   <= ST_IDLE;
      pos_q      <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      shift_q    <= 8'h00;
      bit_idx_q  <= 3'd0;
      lead_cnt_q <= '0;
      lead_run_q <= 1'b0;
      status_q   <= STATUS_IDLE;
    end else begin
      state_q    <= state_d;
      resume_q   <= resume_d;
      pos_q      <= pos_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      lead_cnt_q <= lead_cnt_d;
      lead_run_q <= lead_run_d;
      status_q   <= status_d;
    end
  end

  assign mem.mem_addr_o = addr_q;
  assign mem.mem_rd_o   = rd_q;
  assign data_o         = wave;
  assign status_o       = status_q;

endmodule

// File: tb/tb_svi_cas_player.sv
// Self-checking bench for svi_cas_player with shortened tone timing.
module tb_svi_cas_player;
  import svi_cas_pkg::*;

  localparam int AW       = 8;
  localparam int H1       = 4;
  localparam int H0       = 8;
  localparam int LC       = 3;
  localparam int LEAD_LEN = 2 * H1 * LC;      // 24 clocks of leader tone
  localparam int BIT_LEN  = 2 * H0;           // 16 clocks per bit
  localparam int BYTE_LEN = 2 + 9 * BIT_LEN;  // gap + start bit + 8 data bits

  logic          clk    = 1'b0;
  logic          rst    = 1'b0;
  logic          play   = 1'b0;
  logic          rewind = 1'b0;
  logic [AW-1:0] size   = '0;
  logic          data;
  logic [2:0]    status;

  svi_cas_player_if #(.ADDR_W(AW)) mem_if ();

  svi_cas_player #(
    .ADDR_W     (AW),
    .HALF_1     (H1),
    .HALF_0     (H0),
    .LEADER_CYC (LC)
  ) dut (
    .clk_sys  (clk),
    .reset    (rst),
    .play_i   (play),
    .rewind_i (rewind),
    .size_i   (size),
    .mem      (mem_if),
    .data_o   (data),
    .status_o (status)
  );

  always #5 clk = ~clk;

  // Buffer model: registered read, one cycle latency; every read is logged
  logic [7:0] ram [256];
  int         rd_log[$];
  always @(posedge clk) begin
    if (mem_if.mem_rd_o === 1'b1) begin
      mem_if.mem_data_i <= ram[mem_if.mem_addr_o];
      rd_log.push_back(int'(mem_if.mem_addr_o));
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change just after the rising edge, outputs are sampled on the falling edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Rewind, then request playback; cycle 0 is the first cycle in LEADER
  task automatic start_play(input int s);
    cyc();
    rewind = 1'b1;
    play   = 1'b0;
    cyc();
    rewind = 1'b0;
    size   = AW'(s);
    play   = 1'b1;
    rd_log.delete();
  endtask

  // Reference waveform: one sample per clock starting at cycle 0
  bit exp_w[$];
  task automatic build_model(input int n);
    logic [8:0] frame;
    exp_w.delete();
    exp_w.push_back(1'b0);
    repeat (LC) begin
      repeat (H1) exp_w.push_back(1'b1);
      repeat (H1) exp_w.push_back(1'b0);
    end
    for (int b = 0; b < n; b++) begin
      frame = {1'b1, ram[b]};
      exp_w.push_back(1'b0);
      exp_w.push_back(1'b0);
      for (int i = 8; i >= 0; i--) begin
        if (frame[i]) begin
          repeat (2) begin
            repeat (H1) exp_w.push_back(1'b1);
            repeat (H1) exp_w.push_back(1'b0);
          end
        end else begin
          repeat (H0) exp_w.push_back(1'b1);
          repeat (H0) exp_w.push_back(1'b0);
        end
      end
    end
  endtask

  typedef struct {
    logic [7:0] d;
    int         edges;
    int         reads;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   exp_bits[9];
    int   bit_edges[9];
    int   rises;
    logic prev;

    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    mem_if.mem_data_i = 8'h00;

    // Transitions per frame = half-periods: start 4 + 4 per one + 2 per zero
    vecs[0] = '{8'hA5, 28, 1};
    vecs[1] = '{8'h00, 20, 1};
    vecs[2] = '{8'hFF, 36, 1};
    vecs[3] = '{8'h81, 24, 1};
    vecs[4] = '{8'h3C, 28, 1};
    exp_bits = '{4, 4, 2, 4, 2, 2, 4, 2, 4};

    // Asynchronous reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_status", 32'(status), 32'(STATUS_IDLE));
    chk("rst_data",   32'(data), 0);
    chk("rst_rd",     32'(mem_if.mem_rd_o), 0);
    chk("rst_addr",   32'(mem_if.mem_addr_o), 0);
    cyc();
    cyc();
    rst = 1'b0;

    // Leader timing, A5 bit encoding, then rewind mid-byte with size 0
    ram[0] = 8'hA5; ram[1] = 8'h11; ram[2] = 8'h22; ram[3] = 8'h33;
    start_play(4);
    rises = 0;
    prev  = 1'b0;
    for (int i = 0; i < 9; i++) bit_edges[i] = 0;
    for (int k = 0; k <= 200; k++) begin
      cyc();
      if (k == 180) begin
        rewind = 1'b1;
        size   = '0;
      end
      if (k == 181) rewind = 1'b0;
      smp();
      if (k == 0) begin
        chk("lead_status0", 32'(status), 32'(STATUS_LEADER));
        chk("lead_data0",   32'(data), 0);
      end
      if (k == 1) chk("lead_first_rise", 32'(data), 1);
      if (k == LEAD_LEN) chk("lead_status_last", 32'(status), 32'(STATUS_LEADER));
      if (k == LEAD_LEN + 1) begin
        chk("data_status", 32'(status), 32'(STATUS_DATA));
        chk("fetch_rd",    32'(mem_if.mem_rd_o), 1);
        chk("fetch_addr",  32'(mem_if.mem_addr_o), 0);
      end
      if (k == LEAD_LEN + 2) chk("fetch_rd_pulse", 32'(mem_if.mem_rd_o), 0);
      if (k >= 1 && k <= LEAD_LEN && data && !prev) rises++;
      if (k >= LEAD_LEN + 3 && k < LEAD_LEN + 3 + 9 * BIT_LEN && data !== prev)
        bit_edges[(k - LEAD_LEN - 3) / BIT_LEN]++;
      if (k == 181) begin
        chk("rew_status", 32'(status), 32'(STATUS_IDLE));
        chk("rew_addr",   32'(mem_if.mem_addr_o), 0);
        chk("rew_data",   32'(data), 0);
        chk("rew_rd",     32'(mem_if.mem_rd_o), 0);
      end
      if (k == 200) chk("rew_idle_size0", 32'(status), 32'(STATUS_IDLE));
      prev = data;
    end
    chk("lead_cycles", 32'(rises), 32'(LC));
    for (int i = 0; i < 9; i++) chk("a5_bit_toggles", 32'(bit_edges[i]), 32'(exp_bits[i]));
    chk("rew_reads", 32'(rd_log.size()), 2);
    if (rd_log.size() == 2) begin
      chk("rew_read_addr0", 32'(rd_log[0]), 0);
      chk("rew_read_addr1", 32'(rd_log[1]), 1);
    end
    $display("seq leader/A5/rewind: leader_cycles=%0d reads=%0d", rises, rd_log.size());

    // Table: single-byte images, frame transitions and read count
    for (int v = 0; v < 5; v++) begin
      int   edges;
      int   n2;
      bit   done;
      ram[0] = vecs[v].d;
      start_play(1);
      edges = 0;
      n2    = 0;
      done  = 1'b0;
      prev  = 1'b0;
      for (int k = 0; k < 400 && !done; k++) begin
        cyc();
        smp();
        if (status == STATUS_DATA) begin
          if (data !== prev) edges++;
          n2++;
        end
        prev = data;
        if (status == STATUS_END) done = 1'b1;
      end
      chk("vec_end_reached", 32'(done), 1);
      chk("vec_edges",       32'(edges), 32'(vecs[v].edges));
      chk("vec_data_len",    32'(n2), 32'(BYTE_LEN));
      chk("vec_reads",       32'(rd_log.size()), 32'(vecs[v].reads));
      chk("vec_end_data",    32'(data), 0);
      $display("vec %0d byte=%02h edges=%0d data_clocks=%0d reads=%0d", v, vecs[v].d, edges, n2, rd_log.size());
    end

    // Pause on the 3rd clock of the first HALF_0 half-period of byte 00
    ram[0] = 8'h00;
    start_play(1);
    for (int k = 0; k <= 160; k++) begin
      cyc();
      if (k == 45)  play = 1'b0;
      if (k == 145) play = 1'b1;
      smp();
      if (k == 43) chk("pause_half_start", 32'(data), 1);
      if (k == 45) chk("pause_status_pre", 32'(status), 32'(STATUS_DATA));
      if (k == 46 || k == 145) begin
        chk("pause_status", 32'(status), 32'(STATUS_PAUSED));
        chk("pause_frozen", 32'(data), 1);
      end
      if (k == 146) chk("resume_status", 32'(status), 32'(STATUS_DATA));
      if (k == 150) chk("resume_last_high", 32'(data), 1);
      if (k == 151) chk("resume_toggle", 32'(data), 0);
    end
    $display("seq pause: status_after=%0d data_after=%0b", status, data);

    // Randomized images against the reference waveform
    for (int it = 0; it < 4; it++) begin
      int n;
      int mism;
      int first_bad;
      int exp_s;
      bit exp_d;
      n = (it == 0) ? 2 : int'($urandom_range(1, 3));
      for (int b = 0; b < n; b++) ram[b] = 8'($urandom);
      build_model(n);
      start_play(n);
      mism      = 0;
      first_bad = -1;
      for (int k = 0; k < exp_w.size() + 8; k++) begin
        cyc();
        smp();
        exp_d = (k < exp_w.size()) ? exp_w[k] : 1'b0;
        exp_s = (k <= LEAD_LEN) ? 1 : ((k < exp_w.size()) ? 2 : 4);
        if (data !== exp_d || int'(status) != exp_s) begin
          mism++;
          if (first_bad < 0) first_bad = k;
        end
      end
      chk("model_wave_status", 32'(mism), 0);
      chk("model_reads", 32'(rd_log.size()), 32'(n));
      for (int i = 0; i < rd_log.size() && i < n; i++) chk("model_read_addr", 32'(rd_log[i]), 32'(i));
      chk("model_end_status", 32'(status), 32'(STATUS_END));
      $display("rand %0d size=%0d clocks=%0d mismatched_clocks=%0d first_at=%0d", it, n, exp_w.size(), mism, first_bad);
    end

    // Asynchronous reset in the middle of a data bit
    ram[0] = 8'hFF;
    start_play(1);
    for (int k = 0; k <= 60; k++) begin
      cyc();
      smp();
    end
    chk("pre_areset_status", 32'(status), 32'(STATUS_DATA));
    #2 rst = 1'b1;
    #1;
    chk("areset_status", 32'(status), 0);
    chk("areset_data",   32'(data), 0);
    chk("areset_rd",     32'(mem_if.mem_rd_o), 0);
    chk("areset_addr",   32'(mem_if.mem_addr_o), 0);
    play = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    smp();
    chk("post_areset_idle", 32'(status), 32'(STATUS_IDLE));
    $display("seq async reset: status=%0d data=%0b", status, data);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
